servisia_sram_arb: RTL

SERVISIA_SRAM_ARB -- requirements
Module: servisia_sram_arb

---
 rtl/servisia_sram_arb_pkg.sv | 28 ++
 rtl/servisia_sram_arb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/servisia_sram_arb_pkg.sv
// rtl/servisia_sram_arb_pkg.sv - shared types and constants for the SRAM byte/word arbiter
package servisia_sram_arb_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_LANE = byte_idx_t'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_RWAIT = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input byte_idx_t k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/servisia_sram_arb.sv
// rtl/servisia_sram_arb.sv - single-port SRAM arbiter: core byte port (priority) vs serialised 32-bit word port
// Optional byte-select write masking: SERVISIA_SRAM_ARB_BYTE_SEL_EN
module servisia_sram_arb
    import servisia_sram_arb_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] core_waddr_i,
    input  logic [AW-1:0] core_raddr_i,
    input  logic [7:0]    core_wdata_i,
    input  logic          core_wen_i,
    input  logic          core_ren_i,
    output logic [7:0]    core_rdata_o,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    output logic [31:0]   wb_rdt_o,
    output logic          wb_ack_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [7:0]    sram_wdata_o,
    output logic          sram_we_o,
    output logic          sram_re_o,
    input  logic [7:0]    sram_rdata_i
);

    state_e        state_q, state_d;
    byte_idx_t     idx_q, idx_d;
    logic [AW-3:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [23:0]   rbuf_q, rbuf_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          cap_vld_q, cap_vld_d;
    byte_idx_t     cap_idx_q, cap_idx_d;

    logic          core_busy;
    logic          slot_skip;
    logic          slot_issue;
    logic          unused_bits;

`ifdef SERVISIA_SRAM_ARB_BYTE_SEL_EN
    logic [3:0]    sel_q, sel_d;

    // Masked write lanes burn their slot without touching the SRAM, so they never wait on the core.
    assign slot_skip   = (state_q == ST_XFER) && we_q && !sel_q[idx_q];
    assign unused_bits = ^wb_adr_i[1:0];
`else
    assign slot_skip   = 1'b0;
    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i};
`endif

    assign core_busy    = core_wen_i | core_ren_i;
    assign core_rdata_o = sram_rdata_i;
    assign wb_ack_o     = (state_q == ST_ACK);
    assign wb_rdt_o     = rdt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            rbuf_q    <= '0;
            rdt_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
`ifdef SERVISIA_SRAM_ARB_BYTE_SEL_EN
            sel_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            rbuf_q    <= rbuf_d;
            rdt_q     <= rdt_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
`ifdef SERVISIA_SRAM_ARB_BYTE_SEL_EN
            sel_q     <= sel_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        rbuf_d     = rbuf_q;
        rdt_d      = rdt_q;
        cap_vld_d  = 1'b0;
        cap_idx_d  = cap_idx_q;
        slot_issue = 1'b0;
`ifdef SERVISIA_SRAM_ARB_BYTE_SEL_EN
        sel_d      = sel_q;
`endif

        // Lanes 0-2 collect in a side buffer; the word output only changes once lane 3 lands.
        if (cap_vld_q) begin
            case (cap_idx_q)
                2'd0:    rbuf_d[7:0]   = sram_rdata_i;
                2'd1:    rbuf_d[15:8]  = sram_rdata_i;
                2'd2:    rbuf_d[23:16] = sram_rdata_i;
                default: rdt_d         = {sram_rdata_i, rbuf_q};
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wb_stb_i) begin
                    state_d = ST_XFER;
                    adr_d   = wb_adr_i[AW-1:2];
                    dat_d   = wb_dat_i;
                    we_d    = wb_we_i;
                    idx_d   = '0;
`ifdef SERVISIA_SRAM_ARB_BYTE_SEL_EN
                    sel_d   = wb_sel_i;
`endif
                end
            end
            ST_XFER: begin
                if (!wb_stb_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    slot_issue = !core_busy && !slot_skip;
                    if (slot_issue || slot_skip) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == LAST_LANE) begin
                            state_d = we_q ? ST_ACK : ST_RWAIT;
                        end
                    end
                    if (slot_issue && !we_q) begin
                        cap_vld_d = 1'b1;
                        cap_idx_d = idx_q;
                    end
                end
            end
            ST_RWAIT: state_d = ST_ACK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_addr_o  = core_waddr_i;
        sram_wdata_o = core_wdata_i;
        sram_we_o    = 1'b0;
        sram_re_o    = 1'b0;
        if (core_wen_i) begin
            sram_we_o = 1'b1;
        end else if (core_ren_i) begin
            sram_addr_o = core_raddr_i;
            sram_re_o   = 1'b1;
        end else if (slot_issue) begin
            sram_addr_o  = {adr_q, idx_q};
            sram_wdata_o = lane_byte(dat_q, idx_q);
            sram_we_o    = we_q;
            sram_re_o    = !we_q;
        end
    end

endmodule
